// File: rtl/wb_dma_copy.sv
// wb_dma_copy: Wishbone block-copy initiator.
// Moves len_i 32-bit words from src_adr_i to dst_adr_i, one read cycle then
// one write cycle per word, with an idle bus cycle after every phase so that
// slaves which toggle ack under a held strobe never see back-to-back strobes.
// A per-phase watchdog aborts a phase that is never acknowledged.
module wb_dma_copy #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_adr_i,
    input  logic [31:0]      dst_adr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    output logic [3:0]       wb_sel_o,
    input  logic             wb_ack_i
);

    // Watchdog counts 0..TIMEOUT-1; the phase aborts on the cycle the count
    // would reach TIMEOUT, so the strobe is high for exactly TIMEOUT cycles.
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    localparam bit              WD_EN   = (TIMEOUT > 0);
    localparam logic [31:0]     ADR_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_GAP_R = 3'd2,
        S_WR    = 3'd3,
        S_GAP_W = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      buf_q, buf_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             err_d;
    logic             cyc_d;
    logic             we_d;
    logic             busy_d;
    logic             done_d;
    logic [31:0]      adr_d;
    logic [31:0]      dat_d;
    logic             phase_ack;
    logic             wd_hit;

    // Ack only counts while our strobe is up; gap cycles ignore it.
    assign phase_ack = wb_stb_o & wb_ack_i;
    assign wd_hit    = WD_EN && (wdog_q == WD_LAST);
    assign wb_sel_o  = 4'hF;

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        wdog_d  = wdog_q;
        err_d   = err_o;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i != '0) begin
                        src_d   = src_adr_i & ADR_MASK;
                        dst_d   = dst_adr_i & ADR_MASK;
                        cnt_d   = len_i;
                        wdog_d  = '0;
                        state_d = S_RD;
                    end else begin
                        // Empty copy: report completion without touching the bus.
                        state_d = S_FIN;
                    end
                end
            end
            S_RD: begin
                if (phase_ack) begin
                    buf_d   = wb_dat_i;
                    state_d = S_GAP_R;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wdog_d = wdog_q + WD_ONE;
                end
            end
            S_GAP_R: begin
                wdog_d  = '0;
                state_d = S_WR;
            end
            S_WR: begin
                if (phase_ack) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = (cnt_q == LEN_W'(1)) ? S_FIN : S_GAP_W;
                end else if (wd_hit) begin
                    // Aborted writes are dropped, not retried.
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wdog_d = wdog_q + WD_ONE;
                end
            end
            S_GAP_W: begin
                wdog_d  = '0;
                state_d = S_RD;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        cyc_d  = (state_d == S_RD) || (state_d == S_WR);
        we_d   = (state_d == S_WR);
        busy_d = cyc_d || (state_d == S_GAP_R) || (state_d == S_GAP_W);
        done_d = (state_d == S_FIN);
        adr_d  = '0;
        dat_d  = '0;
        if (state_d == S_RD) begin
            adr_d = src_d;
        end else if (state_d == S_WR) begin
            adr_d = dst_d;
            dat_d = buf_d;
        end
    end

    // State, datapath and output registers; async reset drops the bus at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            buf_q    <= '0;
            cnt_q    <= '0;
            wdog_q   <= '0;
            err_o    <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            wdog_q   <= wdog_d;
            err_o    <= err_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
            wb_cyc_o <= cyc_d;
            wb_stb_o <= cyc_d;
            wb_we_o  <= we_d;
            wb_adr_o <= adr_d;
            wb_dat_o <= dat_d;
        end
    end

endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: directed bench for wb_dma_copy with a behavioural Wishbone
// memory slave and a transaction-level model of the expected bus phases.
module tb_wb_dma_copy;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] src_adr_i = '0;
    logic [31:0] dst_adr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;

    int n_checks = 0;
    int n_fail = 0;

    // slave state
    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;
    logic        s_ack = 1'b0;
    logic        s_busy = 1'b0;
    int          s_wait = 0;
    logic [31:0] s_dat = '0;
    logic        s_go;
    int          rnd_wait = 0;
    int          max_wait = 0;
    logic        slave_mute = 1'b0;

    // expected-phase model
    int          ph_cnt = 0;
    int          exp_base = 0;
    int          exp_n = 0;
    logic        exp_we  [0:255];
    logic [31:0] exp_adr [0:255];
    logic [31:0] exp_dat [0:255];
    logic        prev_end = 1'b0;
    int          done_cnt = 0;
    int          cmp_rel = 0;

    always #5 clk_i = ~clk_i;

    wb_dma_copy #(.LEN_W(16), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .src_adr_i(src_adr_i), .dst_adr_i(dst_adr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i)
    );

    assign wb_ack_i = s_ack;
    assign wb_dat_i = s_dat;
    assign s_go = s_busy ? (s_wait == 0) : (rnd_wait == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
        end
    endtask

    // random wait-state draw for the next phase
    always @(negedge clk_i) rnd_wait <= int'($urandom_range(max_wait, 0));

    // registered-ack memory slave with optional wait states
    always @(posedge clk_i) begin
        if (pl_en) mem[pl_idx] <= pl_dat;
        if (rst_i) begin
            s_ack  <= 1'b0;
            s_busy <= 1'b0;
            s_wait <= 0;
        end else if (s_ack) begin
            s_ack <= 1'b0;
        end else if (wb_stb_o && !slave_mute) begin
            if (s_go) begin
                s_ack  <= 1'b1;
                s_busy <= 1'b0;
                if (wb_we_o) mem[wb_adr_o[11:2]] <= wb_dat_o;
                else         s_dat <= mem[wb_adr_o[11:2]];
            end else if (!s_busy) begin
                s_wait <= rnd_wait - 1;
                s_busy <= 1'b1;
            end else begin
                s_wait <= s_wait - 1;
            end
        end
    end

    // per-cycle compare against bus rules and the expected phase list
    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("sel_const", {28'd0, wb_sel_o}, 32'h0000_000F);
            chk("adr_align", {30'd0, wb_adr_o[1:0]}, 32'd0);
            chk1("cyc_eq_stb", wb_cyc_o, wb_stb_o);
            if (prev_end) chk1("idle_after_phase", wb_stb_o, 1'b0);
            if (done_o) chk1("busy_low_at_done", busy_o, 1'b0);
            if (wb_cyc_o) chk1("busy_during_cyc", busy_o, 1'b1);
            if (wb_stb_o && wb_ack_i) begin
                cmp_rel = ph_cnt - exp_base;
                chk1("phase_in_range", (cmp_rel < exp_n), 1'b1);
                if (cmp_rel < exp_n) begin
                    chk1("phase_we", wb_we_o, exp_we[cmp_rel]);
                    chk("phase_adr", wb_adr_o, exp_adr[cmp_rel]);
                    if (exp_we[cmp_rel]) chk("phase_wdat", wb_dat_o, exp_dat[cmp_rel]);
                end
                ph_cnt <= ph_cnt + 1;
            end
            prev_end <= wb_stb_o && wb_ack_i;
            if (done_o) done_cnt <= done_cnt + 1;
        end
    end

    task automatic poke(input logic [9:0] idx, input logic [31:0] d);
        pl_idx = idx;
        pl_dat = d;
        pl_en  = 1'b1;
        @(posedge clk_i);
        #1 pl_en = 1'b0;
    endtask

    // Copy semantics: word i is read at src+4i then written unchanged to dst+4i.
    task automatic expect_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] a;
        exp_base = ph_cnt;
        exp_n    = 2 * len;
        for (int i = 0; i < len; i++) begin
            a = src + 32'(4 * i);
            exp_we[2*i]    = 1'b0;
            exp_adr[2*i]   = a;
            exp_dat[2*i]   = '0;
            exp_we[2*i+1]  = 1'b1;
            exp_adr[2*i+1] = dst + 32'(4 * i);
            exp_dat[2*i+1] = mem[a[11:2]];
        end
    endtask

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int maxw, input int exp_cyc, input bit inject);
        int got;
        int d0;
        int bound;
        logic saw_cyc;
        logic saw_busy;
        logic [31:0] a;
        max_wait = maxw;
        expect_copy(src, dst, len);
        d0 = done_cnt;
        got = 0;
        saw_cyc = 1'b0;
        saw_busy = 1'b0;
        bound = len * 20 + 40;
        @(negedge clk_i);
        src_adr_i = src;
        dst_adr_i = dst;
        len_i     = len[15:0];
        start_i   = 1'b1;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                start_i = 1'b0;
                chk1("err_cleared_on_start", err_o, 1'b0);
            end
            if (inject && k == 9) begin
                src_adr_i = 32'h0000_0C00;
                dst_adr_i = 32'h0000_0E00;
                len_i     = 16'd2;
                start_i   = 1'b1;
            end
            if (inject && k == 10) start_i = 1'b0;
            if (wb_cyc_o) saw_cyc = 1'b1;
            if (busy_o) saw_busy = 1'b1;
            if (done_o) begin
                got = k;
                break;
            end
        end
        chk1("done_seen", (got > 0), 1'b1);
        if (exp_cyc > 0) chk("done_cycle", got, exp_cyc);
        chk1("err_at_done", err_o, 1'b0);
        if (len == 0) begin
            chk1("len0_no_cyc", saw_cyc, 1'b0);
            chk1("len0_no_busy", saw_busy, 1'b0);
        end
        repeat (3) @(negedge clk_i);
        chk("done_pulses", done_cnt - d0, 32'd1);
        chk("phases_total", ph_cnt - exp_base, exp_n);
        chk1("idle_cyc", wb_cyc_o, 1'b0);
        chk1("idle_busy", busy_o, 1'b0);
        for (int i = 0; i < len; i++) begin
            a = dst + 32'(4 * i);
            chk("dst_word", mem[a[11:2]], exp_dat[2*i+1]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int d0;
        int got;
        int stb_n;

        // reset state
        @(negedge clk_i);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk1("rst_cyc", wb_cyc_o, 1'b0);
        chk1("rst_stb", wb_stb_o, 1'b0);
        chk1("rst_we", wb_we_o, 1'b0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'h0000_000F);
        @(negedge clk_i);
        rst_i = 1'b0;

        // preload
        poke(10'h000, 32'h0000_0011);
        poke(10'h001, 32'h0000_0022);
        poke(10'h002, 32'h0000_0033);
        poke(10'h003, 32'h0000_0044);
        poke(10'h004, 32'h0000_0055);
        poke(10'h3FE, 32'hCAFE_0001);
        poke(10'h3FF, 32'hCAFE_0002);
        poke(10'h060, 32'hDEAD_BEEF);
        poke(10'h380, 32'hDEAD_BEEF);
        poke(10'h381, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) poke(10'(32'h200 + i), 32'h8000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) poke(10'(32'h300 + i), 32'h9000_0000 + 32'(i));
        for (int i = 0; i < 64; i++) poke(10'(32'h080 + i), (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000);

        // basic 4-word copy, zero-wait slave
        run_copy(32'h0000_0000, 32'h0000_0100, 4, 0, 24, 1'b0);
        chk("copy_w0", mem[10'h040], 32'h0000_0011);
        chk("copy_w1", mem[10'h041], 32'h0000_0022);
        chk("copy_w2", mem[10'h042], 32'h0000_0033);
        chk("copy_w3", mem[10'h043], 32'h0000_0044);

        // empty copy
        run_copy(32'h0000_0000, 32'h0000_0100, 0, 0, 1, 1'b0);

        // single word
        run_copy(32'h0000_0010, 32'h0000_0140, 1, 0, 6, 1'b0);
        chk("single_word", mem[10'h050], 32'h0000_0055);

        // source address wraps through 2^32
        run_copy(32'hFFFF_FFF8, 32'h0000_0300, 4, 0, 24, 1'b0);
        chk("wrap_w0", mem[10'h0C0], 32'hCAFE_0001);
        chk("wrap_w2", mem[10'h0C2], 32'h0000_0011);

        // watchdog abort on a slave that never acks
        slave_mute = 1'b1;
        expect_copy(32'h0, 32'h0000_0160, 0);
        d0 = done_cnt;
        got = 0;
        stb_n = 0;
        @(negedge clk_i);
        src_adr_i = 32'h0;
        dst_adr_i = 32'h0000_0160;
        len_i     = 16'd2;
        start_i   = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_i);
            if (k == 1) start_i = 1'b0;
            if (wb_stb_o) stb_n++;
            if (done_o) begin
                got = k;
                break;
            end
        end
        chk("to_stb_cycles", stb_n, 32'd16);
        chk("to_done_cycle", got, 32'd17);
        chk1("to_err", err_o, 1'b1);
        chk1("to_cyc_low", wb_cyc_o, 1'b0);
        chk1("to_stb_low", wb_stb_o, 1'b0);
        chk1("to_we_low", wb_we_o, 1'b0);
        repeat (3) @(negedge clk_i);
        chk("to_done_pulses", done_cnt - d0, 32'd1);
        chk1("to_err_sticky", err_o, 1'b1);
        slave_mute = 1'b0;
        run_copy(32'h0000_0000, 32'h0000_0160, 2, 0, 12, 1'b0);

        // random wait states over a long block
        run_copy(32'h0000_0200, 32'h0000_0400, 64, 5, -1, 1'b0);
        chk("wait_w0", mem[10'h100], 32'hA5A5_0000);
        chk("wait_w63", mem[10'h13F], (32'd63 * 32'h0101_0101) ^ 32'hA5A5_0000);

        // start while busy is ignored
        run_copy(32'h0000_0800, 32'h0000_0A00, 4, 0, 24, 1'b1);
        chk("busy_w3", mem[10'h283], 32'h8000_0003);
        chk("busy_sentinel0", mem[10'h380], 32'hDEAD_BEEF);
        chk("busy_sentinel1", mem[10'h381], 32'hDEAD_BEEF);

        // reset during a write phase
        expect_copy(32'h0, 32'h0000_0180, 4);
        max_wait = 0;
        got = 0;
        @(negedge clk_i);
        src_adr_i = 32'h0;
        dst_adr_i = 32'h0000_0180;
        len_i     = 16'd4;
        start_i   = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            if (k == 1) start_i = 1'b0;
            if (wb_stb_o && wb_we_o) begin
                got = k;
                break;
            end
        end
        chk("rst_wr_cycle", got, 32'd4);
        d0 = done_cnt;
        #2 rst_i = 1'b1;
        #1;
        chk1("arst_cyc", wb_cyc_o, 1'b0);
        chk1("arst_stb", wb_stb_o, 1'b0);
        chk1("arst_we", wb_we_o, 1'b0);
        chk1("arst_busy", busy_o, 1'b0);
        @(negedge clk_i);
        chk1("arst_no_done", done_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("arst_done_pulses", done_cnt - d0, 32'd0);
        chk("arst_no_write", mem[10'h060], 32'hDEAD_BEEF);
        run_copy(32'h0000_0000, 32'h0000_01C0, 4, 0, 24, 1'b0);
        chk("after_rst_w3", mem[10'h073], 32'h0000_0044);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
